// File: rtl/imem_sync.sv
// imem_sync: registered instruction memory with a valid/stall fetch port and a program-load port.
// Define IMEM_FAULT_EN to trap misaligned and out-of-range fetches.
module imem_sync #(
  parameter int          DEPTH  = 64,
  parameter int          ADDR_W = 32,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic              resp_valid,
  output logic [31:0]       instruction,
  output logic              fault,
  input  logic              prog_start,
  input  logic              prog_we,
  input  logic [31:0]       prog_data,
  input  logic              prog_done,
  output logic              prog_busy,
  output logic              prog_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    RUN,
    PROG
  } state_e;

  state_e state_q, state_d;

  logic [AW:0] ptr_q, ptr_d;
  logic        ovf_q, ovf_d;
  logic        wr_en;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          hold;
  logic          flt;
  logic [AW-1:0] rd_idx;

  assign rd_idx = fetch_addr[AW+1:2];

`ifdef IMEM_FAULT_EN
  logic [ADDR_W-1:0] hi_bits;
  assign hi_bits = fetch_addr >> (AW + 2);
  assign flt = (|fetch_addr[1:0]) | (|hi_bits);
`else
  logic unused_addr;
  assign unused_addr = ^fetch_addr;
  assign flt = 1'b0;
`endif

  assign fetch_ready = (state_q == RUN)
                     && !prog_start
                     && !(valid_q && stall);

  assign accept = fetch_req && fetch_ready;
  assign hold   = valid_q && stall && !prog_start;

  // Loader FSM; a restart in PROG takes priority over a write or done.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (prog_start) begin
          state_d = PROG;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      PROG: begin
        if (prog_start) begin
          ptr_d = '0;
          ovf_d = 1'b0;
        end else begin
          if (prog_we) begin
            if (ptr_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              wr_en = !reset;
              ptr_d = ptr_q + 1'b1;
            end
          end
          if (prog_done) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (1'b1)
      prog_start: valid_d = 1'b0;
      accept: begin
        valid_d = 1'b1;
        fault_d = flt;
        instr_d = flt ? NOP : mem_q[rd_idx];
      end
      hold: valid_d = 1'b1;
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Storage is deliberately not reset so programs survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr_q[AW-1:0]] <= prog_data;
    end
  end

  assign resp_valid  = valid_q;
  assign instruction = instr_q;
  assign fault       = fault_q;
  assign prog_busy   = (state_q == PROG);
  assign prog_ovf    = ovf_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed vector table, corner sequences and a
// randomized run against a behavioural model of imem_sync.
module tb_imem_sync;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WA    = 32'h0010_0093;
  localparam logic [31:0] WB    = 32'h0020_0113;
  localparam logic [31:0] D0    = 32'hA500_0000;
  localparam logic [31:0] W0    = 32'h0C00_0000;
`ifdef IMEM_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] instruction;
  logic        fault;
  logic        prog_start;
  logic        prog_we;
  logic [31:0] prog_data;
  logic        prog_done;
  logic        prog_busy;
  logic        prog_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_sync #(.DEPTH(DEPTH), .ADDR_W(32), .NOP(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .instruction(instruction),
    .fault      (fault),
    .prog_start (prog_start),
    .prog_we    (prog_we),
    .prog_data  (prog_data),
    .prog_done  (prog_done),
    .prog_busy  (prog_busy),
    .prog_ovf   (prog_ovf)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stl;
    logic        start;
    logic        we;
    logic [31:0] data;
    logic        done;
    logic        rdy;
    logic        vld;
    logic [31:0] ins;
    logic        flt;
    logic        busy;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(
    input logic req, input logic [31:0] addr,
    input logic stl, input logic start,
    input logic we, input logic [31:0] data,
    input logic done, input logic rdy,
    input logic vld, input logic [31:0] ins,
    input logic flt, input logic busy,
    input logic ovf);
    vec_t v;
    v.req = req; v.addr = addr; v.stl = stl;
    v.start = start; v.we = we; v.data = data;
    v.done = done; v.rdy = rdy; v.vld = vld;
    v.ins = ins; v.flt = flt; v.busy = busy;
    v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset      = 1'b0;
    fetch_req  = v.req;
    fetch_addr = v.addr;
    stall      = v.stl;
    prog_start = v.start;
    prog_we    = v.we;
    prog_data  = v.data;
    prog_done  = v.done;
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".ready"}, 32'(fetch_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(resp_valid), 32'(v.vld));
    chk({tag, ".instr"}, instruction, v.ins);
    chk({tag, ".fault"}, 32'(fault), 32'(v.flt));
    chk({tag, ".busy"}, 32'(prog_busy), 32'(v.busy));
    chk({tag, ".ovf"}, 32'(prog_ovf), 32'(v.ovf));
  endtask

  // behavioural model state
  logic [31:0] m_mem [DEPTH];
  int          m_ptr;
  bit          m_busy, m_ovf, m_vld, m_flt;
  logic [31:0] m_ins;

  vec_t tbl [13];
  vec_t v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, NOP, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, WA, 0, 0, 0, NOP, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, WB, 1, 0, 0, NOP, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 1, WA,  0, 0, 0);
    tbl[4]  = mk(1, 4, 0, 0, 0, 0,  0, 1, 1, WB,  0, 0, 0);
    tbl[5]  = mk(1, 4, 0, 0, 0, 0,  0, 1, 1, WB,  0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 0, 0, 0,  0, 0, 1, WB,  0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0,  0, 0, 1, WB,  0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0,  0, 0, 1, WB,  0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 1, WA,  0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, WA,  0, 0, 0);
    tbl[11] = mk(1, 4, 0, 1, 0, 0,  0, 0, 0, WA,  0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, WA,  0, 0, 0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.valid", 32'(resp_valid), 0);
    chk("rst.instr", instruction, NOP);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.busy", 32'(prog_busy), 0);
    chk("rst.ovf", 32'(prog_ovf), 0);
    chk("rst.ready", 32'(fetch_ready), 1);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // overflow: 17 writes into 16 words
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, WA, 0, 1, 0), "ov.start");
    for (int i = 0; i < 17; i++) begin
      step(mk(0, 0, 0, 0, 1, D0 + 32'(i), 0, 0, 0, WA, 0, 1,
              logic'(i == 16)), $sformatf("ov.w%0d", i));
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, WA, 0, 0, 1), "ov.done");
    step(mk(1, 60, 0, 0, 0, 0, 0, 1, 1, D0 + 15, 0, 0, 1), "ov.rd15");
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, D0 + 15, 0, 1, 0), "ov.clr");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, D0 + 15, 0, 0, 0), "ov.end");

    // misaligned and out-of-range fetches
    step(mk(1, 2, 0, 0, 0, 0, 0, 1, 1, FEN ? NOP : D0, FEN, 0, 0),
         "flt.mis");
    step(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 1, FEN ? NOP : D0, FEN, 0, 0),
         "flt.oor");
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, D0, 0, 0, 0), "flt.ok");

    // reset in the middle of programming
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, D0, 0, 1, 0), "rp.start");
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 0, 0, 1, W0 + 32'(i), 0, 0, 0, D0, 0, 1, 0),
           $sformatf("rp.w%0d", i));
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rp.busy", 32'(prog_busy), 0);
    chk("rp.valid", 32'(resp_valid), 0);
    chk("rp.instr", instruction, NOP);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 32'(4 * i), 0, 0, 0, 0, 0, 1, 1, W0 + 32'(i), 0, 0, 0),
           $sformatf("rp.rd%0d", i));
    end

    // random run against the model
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = (i < 3) ? W0 + 32'(i) : D0 + 32'(i);
    end
    m_ptr = 0; m_busy = 0; m_ovf = 0;
    m_vld = 1; m_ins = W0 + 2; m_flt = 0;

    for (int c = 0; c < 3000; c++) begin
      bit rst, acc, rdy;
      int r, a;
      rst = ($urandom % 100) == 0;
      v.start = ($urandom % 25) == 0;
      v.we    = !v.start && ($urandom % 2 == 0);
      v.done  = !v.start && ($urandom % 8 == 0);
      v.req   = ($urandom % 4) != 0;
      v.stl   = ($urandom % 3) == 0;
      v.data  = $urandom;
      r = int'($urandom % 10);
      if (r < 7) a = int'($urandom % DEPTH) * 4;
      else if (r == 7)
        a = int'($urandom % DEPTH) * 4 + int'($urandom_range(1, 3));
      else a = int'($urandom % 1024);
      v.addr = 32'(a);
      drive(v);
      reset = rst;
      #1;
      rdy = !m_busy && !v.start && !(m_vld && v.stl);
      chk("rnd.ready", 32'(fetch_ready), 32'(rdy));
      acc = v.req && rdy;
      if (rst) begin
        m_busy = 0; m_ptr = 0; m_ovf = 0;
        m_vld = 0; m_ins = NOP; m_flt = 0;
      end else begin
        if (v.start) m_vld = 0;
        else if (acc) begin
          m_vld = 1;
          m_flt = FEN && ((a % 4) != 0 || a >= 4 * DEPTH);
          m_ins = m_flt ? NOP : m_mem[(a / 4) % DEPTH];
        end else if (!(m_vld && v.stl)) m_vld = 0;
        if (v.start) begin
          m_busy = 1; m_ptr = 0; m_ovf = 0;
        end else if (m_busy) begin
          if (v.we) begin
            if (m_ptr == DEPTH) m_ovf = 1;
            else begin
              m_mem[m_ptr] = v.data;
              m_ptr++;
            end
          end
          if (v.done) m_busy = 0;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd.valid", 32'(resp_valid), 32'(m_vld));
      chk("rnd.instr", instruction, m_ins);
      chk("rnd.fault", 32'(fault), 32'(m_flt));
      chk("rnd.busy", 32'(prog_busy), 32'(m_busy));
      chk("rnd.ovf", 32'(prog_ovf), 32'(m_ovf));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
